// File: rtl/memory_block_pkg.sv
// memory_block_pkg
//   Shared types and helpers for memory_block_pipelined.
//   - rdw_mode_e   : same-address read-during-write policy encoding
//   - init_state_e : init-sweep FSM states
//   - strb_merge   : byte-strobe merge of two words
//   - byte_parity  : per-byte even-parity bits (used only when
//                    MEMORY_BLOCK_PIPELINED_PARITY_EN is defined)
//   The helpers operate on MAXW-bit words; callers zero-extend and
//   truncate to their own DATAW.
package memory_block_pkg;

  localparam int MAXW = 1024;
  localparam int MAXB = MAXW / 8;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } init_state_e;

  function automatic logic [MAXW-1:0] strb_merge(input logic [MAXW-1:0] old_w,
                                                 input logic [MAXW-1:0] new_w,
                                                 input logic [MAXB-1:0] strb);
    logic [MAXW-1:0] mask;
    for (int i = 0; i < MAXB; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Bit i is the XOR of byte i, so byte plus parity bit has even weight.
  function automatic logic [MAXB-1:0] byte_parity(input logic [MAXW-1:0] data);
    logic [MAXB-1:0] p;
    for (int i = 0; i < MAXB; i++) begin
      p[i] = ^data[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe
//   Valid/data delay line of STAGES registers (STAGES >= 1) with
//   asynchronous active-high reset. Every stage, valid and data, clears
//   on reset so nothing in flight survives it.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset
//   vld_i   valid into the first stage
//   data_i  payload into the first stage
//   vld_o   valid out of the last stage
//   data_o  payload out of the last stage
module mem_rd_pipe
  import memory_block_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[STAGES-1];
  assign data_o = data_q[STAGES-1];

endmodule

// File: rtl/memory_block_pipelined.sv
// memory_block_pipelined
//   One-write/one-read memory with byte strobes, RD_LAT-cycle read
//   latency with a valid flag, selectable same-address read-during-write
//   policy, and a post-reset zero-fill sweep gated by ready_o.
//   Optional macro MEMORY_BLOCK_PIPELINED_PARITY_EN adds one even-parity
//   bit per stored byte and the rerr_o output.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   ready_o   high once the init sweep has finished
//   wen_i     write enable (ignored while ready_o=0)
//   waddr_i   write address
//   wstrb_i   byte write strobes, bit i covers wdata_i[8i+7:8i]
//   wdata_i   write data
//   ren_i     read enable (ignored while ready_o=0)
//   raddr_i   read address
//   rvalid_o  read data valid, RD_LAT cycles after an accepted read
//   rdata_o   read data, holds its last value while rvalid_o is low
//   rerr_o    (parity build only) stored parity mismatch on this read
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | zero-filling address init_cnt_q each cycle, ports gated off
// ST_RUN  | normal operation, ready_o high, left only through reset
module memory_block_pipelined
  import memory_block_pkg::*;
#(
  parameter int DATAW    = 128,
  parameter int DEPTH    = 64,
  parameter int ADDRW    = $clog2(DEPTH),
  parameter int RD_LAT   = 2,
  parameter int RDW_MODE = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               ready_o,
  input  logic               wen_i,
  input  logic [ADDRW-1:0]   waddr_i,
  input  logic [DATAW/8-1:0] wstrb_i,
  input  logic [DATAW-1:0]   wdata_i,
  input  logic               ren_i,
  input  logic [ADDRW-1:0]   raddr_i,
  output logic               rvalid_o,
  output logic [DATAW-1:0]   rdata_o
`ifdef MEMORY_BLOCK_PIPELINED_PARITY_EN
  ,
  output logic               rerr_o
`endif
);

  localparam int NB = DATAW / 8;
`ifdef MEMORY_BLOCK_PIPELINED_PARITY_EN
  localparam int PW = DATAW + 1;  // payload = {err, data}
`else
  localparam int PW = DATAW;
`endif
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
  localparam logic [ADDRW:0]   DEPTH_W   = (ADDRW + 1)'(DEPTH);

  if ((DATAW % 8) != 0 || DATAW > MAXW) begin : g_bad_dataw
    $error("memory_block_pipelined: DATAW must be a multiple of 8 and <= %0d", MAXW);
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("memory_block_pipelined: DEPTH must be at least 2");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("memory_block_pipelined: RD_LAT must be in 1..4");
  end
  if (RDW_MODE < 0 || RDW_MODE > 1) begin : g_bad_rdw
    $error("memory_block_pipelined: RDW_MODE must be 0 or 1");
  end

  // ---------------- init FSM ----------------
  init_state_e      state_q, state_d;
  logic [ADDRW-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDRW'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  logic run;
  assign run     = (state_q == ST_RUN);
  assign ready_o = run;

  // ---------------- storage and write port ----------------
  logic [DATAW-1:0] mem_q [DEPTH];
  logic             waddr_ok, raddr_ok, wr_acc, rd_acc, collide, rd_fwd;
  logic [DATAW-1:0] wr_merged;

  assign waddr_ok  = ({1'b0, waddr_i} < DEPTH_W);
  assign raddr_ok  = ({1'b0, raddr_i} < DEPTH_W);
  assign wr_acc    = run && wen_i && waddr_ok;
  assign rd_acc    = run && ren_i;
  assign wr_merged = DATAW'(strb_merge(MAXW'(mem_q[waddr_i]), MAXW'(wdata_i), MAXB'(wstrb_i)));

  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_acc) begin
      mem_q[waddr_i] <= wr_merged;
    end
  end

`ifdef MEMORY_BLOCK_PIPELINED_PARITY_EN
  logic [NB-1:0]   par_q [DEPTH];
  logic [MAXB-1:0] wr_par_full;
  logic [NB-1:0]   wr_par_new;

  assign wr_par_full = byte_parity(MAXW'(wdata_i));
  assign wr_par_new  = (par_q[waddr_i] & ~wstrb_i) | (wr_par_full[NB-1:0] & wstrb_i);

  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      par_q[init_cnt_q] <= '0;
    end else if (wr_acc) begin
      par_q[waddr_i] <= wr_par_new;
    end
  end
`endif

  // ---------------- read stage 1 and collision mux ----------------
  // Forwarding only matters in new-data mode; in old-data mode the
  // array read already returns pre-write contents.
  assign collide = wr_acc && (waddr_i == raddr_i);
  assign rd_fwd  = (RDW_MODE == int'(RDW_NEW)) && collide;

  logic [DATAW-1:0] rd_old, rd_word;
  logic [PW-1:0]    s1_pay_d, s1_pay_q;
  logic             s1_vld_q;
`ifdef MEMORY_BLOCK_PIPELINED_PARITY_EN
  logic [MAXB-1:0]  rd_par_calc;
  logic             rd_err;
`endif

  always_comb begin
    rd_old  = '0;
    if (raddr_ok) begin
      rd_old = mem_q[raddr_i];
    end
    rd_word = rd_fwd ? DATAW'(strb_merge(MAXW'(rd_old), MAXW'(wdata_i), MAXB'(wstrb_i)))
                     : rd_old;
`ifdef MEMORY_BLOCK_PIPELINED_PARITY_EN
    // Forwarded words carry freshly computed parity, so they cannot flag.
    rd_par_calc = byte_parity(MAXW'(rd_old));
    rd_err      = raddr_ok && !rd_fwd && (rd_par_calc[NB-1:0] != par_q[raddr_i]);
    s1_pay_d    = {rd_err, rd_word};
`else
    s1_pay_d    = rd_word;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s1_pay_q <= '0;
    end else begin
      s1_vld_q <= rd_acc;
      s1_pay_q <= s1_pay_d;
    end
  end

  // ---------------- stages 2..RD_LAT ----------------
  logic          fin_vld;
  logic [PW-1:0] fin_pay;

  if (RD_LAT > 1) begin : g_pipe
    mem_rd_pipe #(
      .WIDTH (PW),
      .STAGES(RD_LAT - 1)
    ) u_rd_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .vld_i (s1_vld_q),
      .data_i(s1_pay_q),
      .vld_o (fin_vld),
      .data_o(fin_pay)
    );
  end else begin : g_no_pipe
    assign fin_vld = s1_vld_q;
    assign fin_pay = s1_pay_q;
  end

  // ---------------- output hold ----------------
  // rdata_o shows the final stage directly when valid so RD_LAT counts
  // edges exactly; the hold register keeps it stable between reads.
  logic [DATAW-1:0] rdata_hold_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_hold_q <= '0;
    end else if (fin_vld) begin
      rdata_hold_q <= fin_pay[DATAW-1:0];
    end
  end

  assign rvalid_o = fin_vld;
  assign rdata_o  = fin_vld ? fin_pay[DATAW-1:0] : rdata_hold_q;
`ifdef MEMORY_BLOCK_PIPELINED_PARITY_EN
  assign rerr_o   = fin_vld & fin_pay[DATAW];
`endif

endmodule

// File: tb/tb_memory_block_pipelined.sv
// Scoreboard bench for memory_block_pipelined. Two instances share the
// stimulus: u_dut0 (RD_LAT=2, old-data collisions) and u_dut1 (RD_LAT=3,
// new-data collisions). Stimulus pushes expected read responses, tagged
// with their due cycle, into one queue per instance; a negedge monitor
// pops and compares whenever rvalid is seen.
module tb_memory_block_pipelined;

  localparam int DATAW = 128;
  localparam int DEPTH = 64;
  localparam int ADDRW = 6;
  localparam int NB    = DATAW / 8;
  localparam int LAT0  = 2;
  localparam int LAT1  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wen = 1'b0;
  logic [ADDRW-1:0] waddr = '0;
  logic [NB-1:0]    wstrb = '0;
  logic [DATAW-1:0] wdata = '0;
  logic             ren = 1'b0;
  logic [ADDRW-1:0] raddr = '0;

  logic             ready0, ready1, rvalid0, rvalid1;
  logic [DATAW-1:0] rdata0, rdata1;
  logic             rerr0, rerr1;

  always #5 clk = ~clk;

`ifdef MEMORY_BLOCK_PIPELINED_PARITY_EN
  memory_block_pipelined #(.DATAW(DATAW), .DEPTH(DEPTH), .RD_LAT(LAT0), .RDW_MODE(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .ready_o(ready0), .wen_i(wen), .waddr_i(waddr),
    .wstrb_i(wstrb), .wdata_i(wdata), .ren_i(ren), .raddr_i(raddr),
    .rvalid_o(rvalid0), .rdata_o(rdata0), .rerr_o(rerr0));
  memory_block_pipelined #(.DATAW(DATAW), .DEPTH(DEPTH), .RD_LAT(LAT1), .RDW_MODE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .ready_o(ready1), .wen_i(wen), .waddr_i(waddr),
    .wstrb_i(wstrb), .wdata_i(wdata), .ren_i(ren), .raddr_i(raddr),
    .rvalid_o(rvalid1), .rdata_o(rdata1), .rerr_o(rerr1));
`else
  assign rerr0 = 1'b0;
  assign rerr1 = 1'b0;
  memory_block_pipelined #(.DATAW(DATAW), .DEPTH(DEPTH), .RD_LAT(LAT0), .RDW_MODE(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .ready_o(ready0), .wen_i(wen), .waddr_i(waddr),
    .wstrb_i(wstrb), .wdata_i(wdata), .ren_i(ren), .raddr_i(raddr),
    .rvalid_o(rvalid0), .rdata_o(rdata0));
  memory_block_pipelined #(.DATAW(DATAW), .DEPTH(DEPTH), .RD_LAT(LAT1), .RDW_MODE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .ready_o(ready1), .wen_i(wen), .waddr_i(waddr),
    .wstrb_i(wstrb), .wdata_i(wdata), .ren_i(ren), .raddr_i(raddr),
    .rvalid_o(rvalid1), .rdata_o(rdata1));
`endif

  typedef struct {
    logic [DATAW-1:0] d;
    int               due;
  } exp_t;

  exp_t             expq [2][$];
  logic [DATAW-1:0] last [2];
  logic [DATAW-1:0] model_mem [DEPTH];
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  int               rcnt     = 0;   // edges since reset released
  bit               mon_en   = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) rcnt = 0;
    else if (rcnt < 1000000) rcnt++;
  end

  function automatic logic [DATAW-1:0] merge_bytes(input logic [DATAW-1:0] old_w,
                                                   input logic [DATAW-1:0] new_w,
                                                   input logic [NB-1:0] s);
    logic [DATAW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic [DATAW-1:0] d, input logic e);
    exp_t x;
    if (v === 1'b1) begin
      if (expq[p].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid%0d_unexpected cycle=%0d: got rvalid=1 expected no read pending", p, cyc);
      end else begin
        x = expq[p].pop_front();
        chk($sformatf("latency%0d", p), DATAW'(cyc), DATAW'(x.due));
        chk($sformatf("rdata%0d", p), d, x.d);
        chk($sformatf("rerr%0d", p), DATAW'(e), '0);
        last[p] = x.d;
      end
    end else begin
      chk($sformatf("rdata_hold%0d", p), d, last[p]);
      if (expq[p].size() > 0 && expq[p][0].due <= cyc) begin
        x = expq[p].pop_front();
        checks++;
        failures++;
        $display("FAIL rvalid%0d_missing cycle=%0d: got rvalid=0 expected read due at %0d", p, cyc, x.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready0", DATAW'(ready0), DATAW'(!rst && rcnt >= DEPTH));
      chk("ready1", DATAW'(ready1), DATAW'(!rst && rcnt >= DEPTH));
      mon(0, rvalid0, rdata0, rerr0);
      mon(1, rvalid1, rdata1, rerr1);
    end
  end

  // One cycle of stimulus; the model decides acceptance from its own
  // count of edges since reset release.
  task automatic drive(input bit w, input logic [ADDRW-1:0] wa, input logic [NB-1:0] ws,
                       input logic [DATAW-1:0] wd, input bit r, input logic [ADDRW-1:0] ra);
    exp_t e;
    logic [DATAW-1:0] old;
    @(posedge clk);
    #1;
    wen = w; waddr = wa; wstrb = ws; wdata = wd; ren = r; raddr = ra;
    if (rcnt >= DEPTH) begin
      if (r) begin
        old   = model_mem[ra];
        e.d   = old;
        e.due = cyc + LAT0;
        expq[0].push_back(e);
        e.d   = (w && wa == ra) ? merge_bytes(old, wd, ws) : old;
        e.due = cyc + LAT1;
        expq[1].push_back(e);
      end
      if (w) model_mem[wa] = merge_bytes(model_mem[wa], wd, ws);
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [ADDRW-1:0] a);
    drive(1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic wr(input logic [ADDRW-1:0] a, input logic [NB-1:0] s, input logic [DATAW-1:0] d);
    drive(1'b1, a, s, d, 1'b0, '0);
  endtask

  // Assert reset one ns after an edge; anything still in flight is dropped.
  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wen = 1'b0;
    ren = 1'b0;
    expq[0].delete();
    expq[1].delete();
    last[0] = '0;
    last[1] = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  initial begin
    last[0] = '0;
    last[1] = '0;
    #3;
    rst = 1'b1;
    #1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Port commands during the sweep (and a few after) with random addresses.
    for (int i = 0; i < DEPTH + 4; i++) begin
      drive(1'b1, ADDRW'($urandom_range(DEPTH - 1, 0)), NB'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 1'b1, ADDRW'($urandom_range(DEPTH - 1, 0)));
    end
    // Make sure the next phase starts from a zeroed array.
    do_reset(2);
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'b1, ADDRW'(i), '1, '1, 1'b1, ADDRW'(i));
    end
    rd(6'd0); rd(6'd31); rd(6'd63);
    for (int i = 0; i < DEPTH; i++) rd(ADDRW'(i));
    idle();

    // Byte strobes.
    wr(6'd5, '1, '1);
    wr(6'd5, 16'h0003, '0);
    rd(6'd5);
    idle();

    // Latency and back-to-back throughput.
    for (int a = 1; a <= 4; a++) wr(ADDRW'(a), '1, DATAW'(a * 'h11));
    for (int a = 1; a <= 4; a++) rd(ADDRW'(a));
    repeat (4) idle();

    // Same-address collision, partial strobe.
    wr(6'd7, '1, {NB{8'hAA}});
    drive(1'b1, 6'd7, 16'h00FF, {NB{8'h55}}, 1'b1, 6'd7);
    rd(6'd7);
    // Different-address read and write in the same cycle.
    drive(1'b1, 6'd8, '1, {NB{8'h3C}}, 1'b1, 6'd7);
    rd(6'd8);
    repeat (4) idle();

    // Random traffic on a narrow address range to force collisions.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(1, 0)), ADDRW'($urandom_range(7, 0)), NB'($urandom),
            {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(1, 0)), ADDRW'($urandom_range(7, 0)));
    end
    repeat (4) idle();

    // Reset with two reads in flight.
    rd(6'd1);
    rd(6'd2);
    do_reset(3);
    for (int i = 0; i < DEPTH + 2; i++) idle();
    rd(6'd0); rd(6'd1); rd(6'd2); rd(6'd7); rd(6'd63);
    repeat (8) idle();

    chk("drain0", DATAW'(expq[0].size()), '0);
    chk("drain1", DATAW'(expq[1].size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
